// File: rtl/ram_burst_master.sv
// ram_burst_master: burst initiator for a synchronous single-port RAM with a
// 1-cycle registered read. A command (start address, beats-1, direction) is
// taken on a valid/ready handshake; write bursts move a valid/ready input
// stream into RAM, read bursts return RAM words on a valid/ready output stream
// through a 2-entry skid FIFO so backpressure never drops or reorders data.
//
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   cmd_valid/cmd_ready              command handshake
//   cmd_write, cmd_addr, cmd_len     direction, start address, beats-1
//   wr_valid/wr_ready, wr_data       write data stream (into RAM)
//   rd_valid/rd_ready, rd_data       read data stream (out of RAM)
//   rd_last                          final beat of a read burst
//   ram_addr, ram_din, ram_we        RAM request port
//   ram_dout                         RAM read data (valid cycle after issue)
//   busy                             burst in progress
//   done                             one-cycle pulse after the final beat
module ram_burst_master #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned LEN_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_last,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  output logic                  ram_we,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned CNT_WIDTH = LEN_WIDTH + 1;
  localparam int unsigned OCC_WIDTH = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [CNT_WIDTH-1:0]    beats_left;   // beats still to issue (write: to accept)
  logic [LEN_WIDTH-1:0]    out_left;     // read beats still to deliver, minus one
  logic                    inflight_q;   // RAM read issued last cycle
  logic [DATA_WIDTH-1:0]   fifo_mem [2];
  logic                    fifo_wptr;
  logic                    fifo_rptr;
  logic [1:0]              fifo_cnt;

  logic                    cmd_hs;
  logic                    wr_hs;
  logic                    pop;
  logic                    issue;
  logic [OCC_WIDTH-1:0]    occupancy;

  // Handshakes and stream/RAM port outputs derived from registered state
  assign cmd_hs    = cmd_valid && (state == IDLE);
  assign wr_hs     = wr_valid && (state == WRITE);
  assign pop       = rd_valid && rd_ready;

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign wr_ready  = (state == WRITE);
  assign rd_valid  = (state == READ) && (fifo_cnt != 2'd0);
  assign rd_data   = fifo_mem[fifo_rptr];
  assign rd_last   = rd_valid && (out_left == '0);
  assign ram_addr  = addr_q;
  assign ram_we    = wr_hs;
  assign ram_din   = (state == WRITE) ? wr_data : '0;

  // Issue only if the word will have a FIFO slot once it returns, counting
  // the word already in flight and any slot freed by this cycle's pop.
  always_comb begin
    occupancy = OCC_WIDTH'(fifo_cnt) + OCC_WIDTH'(inflight_q) - OCC_WIDTH'(pop);
    issue     = (state == READ) && (beats_left != '0) && (occupancy < OCC_WIDTH'(2));
  end

  // Burst FSM, address/beat counters, read pipeline and output FIFO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      addr_q     <= '0;
      beats_left <= '0;
      out_left   <= '0;
      inflight_q <= 1'b0;
      fifo_wptr  <= 1'b0;
      fifo_rptr  <= 1'b0;
      fifo_cnt   <= 2'd0;
      done       <= 1'b0;
      for (int i = 0; i < 2; i++) fifo_mem[i] <= '0;
    end else begin
      done       <= 1'b0;
      inflight_q <= issue;

      case (state)
        IDLE: begin
          if (cmd_hs) begin
            addr_q     <= cmd_addr;
            beats_left <= CNT_WIDTH'(cmd_len) + CNT_WIDTH'(1);
            out_left   <= cmd_len;
            state      <= cmd_write ? WRITE : READ;
          end
        end
        WRITE: begin
          if (wr_hs) begin
            addr_q     <= addr_q + ADDR_WIDTH'(1);
            beats_left <= beats_left - CNT_WIDTH'(1);
            if (beats_left == CNT_WIDTH'(1)) begin
              state <= IDLE;
              done  <= 1'b1;
            end
          end
        end
        READ: begin
          if (issue) begin
            addr_q     <= addr_q + ADDR_WIDTH'(1);
            beats_left <= beats_left - CNT_WIDTH'(1);
          end
          if (pop) begin
            if (out_left == '0) begin
              state <= IDLE;
              done  <= 1'b1;
            end else begin
              out_left <= out_left - LEN_WIDTH'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase

      // RAM word returns one cycle after issue
      if (inflight_q) begin
        fifo_mem[fifo_wptr] <= ram_dout;
        fifo_wptr           <= ~fifo_wptr;
      end
      if (pop) fifo_rptr <= ~fifo_rptr;
      fifo_cnt <= fifo_cnt + 2'(inflight_q) - 2'(pop);
    end
  end

endmodule

// File: tb/tb_ram_burst_master.sv
// Bench for ram_burst_master: RAM model, transaction-level reference model
// checked every cycle, and directed bursts with literal expectations.
module tb_ram_burst_master;

  localparam int unsigned DW    = 8;
  localparam int unsigned AW    = 4;
  localparam int unsigned LW    = 4;
  localparam int unsigned DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [LW-1:0] cmd_len;
  logic          wr_valid, wr_ready;
  logic [DW-1:0] wr_data;
  logic          rd_valid, rd_ready, rd_last;
  logic [DW-1:0] rd_data;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din, ram_dout;
  logic          ram_we, busy, done;

  always #5 clk = ~clk;

  ram_burst_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout),
    .busy(busy), .done(done)
  );

  // Synchronous single-port RAM: registered read, write-first
  logic [DW-1:0] ram_mem [DEPTH];
  always @(posedge clk) begin
    if (ram_we) begin
      ram_mem[ram_addr] <= ram_din;
      ram_dout          <= ram_din;
    end else begin
      ram_dout <= ram_mem[ram_addr];
    end
  end

  int checks   = 0;
  int failures = 0;

  // Reference model state (transaction level)
  bit            m_busy, m_wr, m_done;
  logic [AW-1:0] m_addr, m_start;
  int            m_total, m_rem, m_cyc;
  logic [DW-1:0] m_mem [DEPTH];
  logic [DW-1:0] expq [$];
  logic [AW-1:0] wlog [$];
  logic [DW-1:0] rlog [$];
  bit            llog [$];
  int            done_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, then advance the model
  task automatic compare_cycle();
    bit            was_busy;
    bit            nd;
    bit            exp_v;
    logic [AW-1:0] diff;
    int            issued;
    int            delivered;
    if (!rst_n) begin
      chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_rd_valid", 32'(rd_valid), 32'd0);
      chk("rst_ram_we", 32'(ram_we), 32'd0);
      chk("rst_ram_addr", 32'(ram_addr), 32'd0);
      m_busy = 1'b0;
      m_done = 1'b0;
      expq.delete();
      return;
    end
    was_busy = m_busy;
    nd       = 1'b0;
    chk("cmd_ready", 32'(cmd_ready), 32'(!m_busy));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("done", 32'(done), 32'(m_done));
    if (done) done_cnt++;
    chk("wr_ready", 32'(wr_ready), 32'(m_busy && m_wr));
    chk("ram_we", 32'(ram_we), 32'(m_busy && m_wr && wr_valid));
    if (!m_busy) chk("idle_ram_din", 32'(ram_din), 32'd0);
    if (m_busy && m_wr && wr_valid) begin
      chk("wr_addr", 32'(ram_addr), 32'(m_addr));
      chk("wr_din", 32'(ram_din), 32'(wr_data));
      wlog.push_back(ram_addr);
    end
    if (m_busy && !m_wr) begin
      // first beat three cycles after accept, then no gaps while beats remain
      exp_v = (m_cyc >= 3);
      chk("rd_valid", 32'(rd_valid), 32'(exp_v));
      diff      = ram_addr - m_start;
      issued    = int'(diff);
      delivered = m_total - m_rem;
      chk("issue_bound", 32'((issued <= m_total) && (issued >= delivered) &&
                             (issued - delivered <= 2)), 32'd1);
      if (exp_v && rd_ready) begin
        chk("rd_data", 32'(rd_data), 32'(expq[0]));
        chk("rd_last", 32'(rd_last), 32'(m_rem == 1));
        rlog.push_back(rd_data);
        llog.push_back(rd_last);
        void'(expq.pop_front());
        m_rem--;
        if (m_rem == 0) begin
          m_busy = 1'b0;
          nd     = 1'b1;
        end
      end
      m_cyc++;
    end else begin
      chk("rd_valid_off", 32'(rd_valid), 32'd0);
    end
    if (m_busy && m_wr && wr_valid) begin
      m_mem[m_addr] = wr_data;
      m_addr        = m_addr + AW'(1);
      m_rem--;
      if (m_rem == 0) begin
        m_busy = 1'b0;
        nd     = 1'b1;
      end
    end
    if (!was_busy && cmd_valid) begin
      m_busy  = 1'b1;
      m_wr    = cmd_write;
      m_addr  = cmd_addr;
      m_start = cmd_addr;
      m_total = int'(cmd_len) + 1;
      m_rem   = m_total;
      m_cyc   = 1;
      if (!cmd_write)
        for (int i = 0; i < m_total; i++) expq.push_back(m_mem[AW'(int'(cmd_addr) + i)]);
    end
    m_done = nd;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input bit wr, input logic [AW-1:0] a, input logic [LW-1:0] l);
    int t;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_len = l;
    t = 0;
    while (!cmd_ready && t < 20) begin step(); t++; end
    chk("cmd_wait", 32'(cmd_ready), 32'd1);
    step();
    cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input int n, input logic [31:0] d,
                          input bit toggle);
    int i, k;
    bit hs;
    wlog.delete();
    send_cmd(1'b1, a, LW'(n - 1));
    i = 0; k = 0;
    while (i < n && k < 60) begin
      wr_valid = toggle ? (k % 2 == 0) : 1'b1;
      wr_data  = d[8*i +: 8];
      hs       = wr_valid && wr_ready;
      step();
      if (hs) i++;
      k++;
    end
    wr_valid = 1'b0; wr_data = '0;
    chk("write_beats", 32'(i), 32'(n));
    step(); step();
  endtask

  task automatic do_read(input logic [AW-1:0] a, input int n, input int stall_at,
                         input int stall_len, input logic [AW-1:0] stall_addr);
    int got, k, sc;
    bit hs;
    rlog.delete(); llog.delete();
    send_cmd(1'b0, a, LW'(n - 1));
    got = 0; k = 0; sc = 0;
    while (got < n && k < 60) begin
      if (stall_len > 0 && got == stall_at && sc < stall_len) begin
        rd_ready = 1'b0;
        sc++;
      end else begin
        if (stall_len > 0 && got == stall_at && sc == stall_len) begin
          chk("stall_addr", 32'(ram_addr), 32'(stall_addr));
          chk("stall_valid", 32'(rd_valid), 32'd1);
          sc++;
        end
        rd_ready = 1'b1;
      end
      hs = rd_valid && rd_ready;
      step();
      if (hs) got++;
      k++;
    end
    rd_ready = 1'b0;
    chk("read_beats", 32'(got), 32'(n));
    step(); step();
  endtask

  task automatic chk_rlog(input string name, input int n, input logic [31:0] d);
    logic [DW-1:0] e;
    chk({name, "_len"}, 32'(rlog.size()), 32'(n));
    for (int i = 0; i < n && i < rlog.size(); i++) begin
      e = d[8*i +: 8];
      chk(name, 32'(rlog[i]), 32'(e));
      chk({name, "_last"}, 32'(llog[i]), 32'(i == n - 1));
    end
  endtask

  initial begin
    int dc;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
    m_busy = 1'b0; m_wr = 1'b0; m_done = 1'b0; m_addr = '0; m_start = '0;
    m_total = 0; m_rem = 0; m_cyc = 0; done_cnt = 0;
    for (int i = 0; i < DEPTH; i++) begin m_mem[i] = '0; ram_mem[i] = '0; end
    fork
      forever begin
        @(negedge clk);
        compare_cycle();
      end
    join_none
    step(); step();
    rst_n = 1'b1;
    step();

    // write 3..6 with A0..A3, continuous
    dc = done_cnt;
    do_write(4'd3, 4, 32'hA3A2A1A0, 1'b0);
    chk("w1_done_cnt", 32'(done_cnt - dc), 32'd1);
    chk("w1_nbeats", 32'(wlog.size()), 32'd4);
    chk("w1_addr0", 32'(wlog[0]), 32'd3);
    chk("w1_addr3", 32'(wlog[3]), 32'd6);
    chk("w1_model_mem3", 32'(m_mem[3]), 32'hA0);
    chk("w1_model_mem6", 32'(m_mem[6]), 32'hA3);
    chk("w1_busy", 32'(busy), 32'd0);

    // read back, no backpressure
    dc = done_cnt;
    do_read(4'd3, 4, 0, 0, '0);
    chk_rlog("r1", 4, 32'hA3A2A1A0);
    chk("r1_done_cnt", 32'(done_cnt - dc), 32'd1);

    // read back with 5 stall cycles after first beat
    dc = done_cnt;
    do_read(4'd3, 4, 1, 5, 4'd6);
    chk_rlog("r2", 4, 32'hA3A2A1A0);
    chk("r2_done_cnt", 32'(done_cnt - dc), 32'd1);

    // address wrap
    do_write(4'd14, 4, 32'h44332211, 1'b0);
    chk("wrap_addr1", 32'(wlog[1]), 32'd15);
    chk("wrap_addr2", 32'(wlog[2]), 32'd0);
    chk("wrap_addr3", 32'(wlog[3]), 32'd1);
    do_read(4'd14, 4, 0, 0, '0);
    chk_rlog("rwrap", 4, 32'h44332211);

    // write with wr_valid toggling
    dc = done_cnt;
    do_write(4'd8, 4, 32'h08070605, 1'b1);
    chk("wt_nbeats", 32'(wlog.size()), 32'd4);
    chk("wt_addr1", 32'(wlog[1]), 32'd9);
    chk("wt_addr3", 32'(wlog[3]), 32'd11);
    chk("wt_done_cnt", 32'(done_cnt - dc), 32'd1);

    // reset during beat 2 of a 4-beat read
    rlog.delete(); llog.delete();
    send_cmd(1'b0, 4'd3, 4'd3);
    rd_ready = 1'b1;
    begin
      int k = 0;
      while (rlog.size() < 1 && k < 20) begin step(); k++; end
    end
    chk("pre_rst_valid", 32'(rd_valid), 32'd1);
    dc = done_cnt;
    rst_n = 1'b0;
    #1;
    chk("ar_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("ar_wr_ready", 32'(wr_ready), 32'd0);
    chk("ar_rd_valid", 32'(rd_valid), 32'd0);
    chk("ar_rd_last", 32'(rd_last), 32'd0);
    chk("ar_rd_data", 32'(rd_data), 32'd0);
    chk("ar_ram_we", 32'(ram_we), 32'd0);
    chk("ar_ram_addr", 32'(ram_addr), 32'd0);
    chk("ar_ram_din", 32'(ram_din), 32'd0);
    chk("ar_busy", 32'(busy), 32'd0);
    chk("ar_done", 32'(done), 32'd0);
    rd_ready = 1'b0;
    step(); step();
    rst_n = 1'b1;
    step();
    chk("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    do_read(4'd3, 1, 0, 0, '0);
    chk_rlog("rpost", 1, 32'h000000A0);
    chk("rst_done_cnt", 32'(done_cnt - dc), 32'd1);

    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
